chacha_stream_ctrl: RTL and testbench
=====================================

Name: chacha_stream_ctrl

Overview:
Bus master that sequences the chacha register-interface block. It runs a message encryption or decryption as a stream of 32-bit words. It programs rounds, key and IV once, then loops per 64-byte block: load DATA_IN, trigger init (first block) or next (later blocks), poll STATUS, and drain DATA_OUT to a ready/valid output stream. It sits between a host word stream and the chacha block's read/write/addr port.

Parameters:
TIMEOUT_CYCLES, 1024, maximum number of STATUS poll cycles before the controller aborts with error.
CNT_W, 32, width of block_count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; key, iv and rounds are sampled in the same cycle
key  in  256  key; word 0 is bits [255:224]
iv  in  96  nonce; word 0 is bits [95:64]
rounds  in  5  round count written to ROUNDS
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
in_data  in  32  input word
in_last  in  1  marks the final word of the message
out_valid  out  1  output word valid
out_ready  in  1  output sink ready
out_data  out  32  keystream XOR data word
out_last  out  1  marks the final output word
cc_read  out  1  chacha bus read strobe
cc_write  out  1  chacha bus write strobe
cc_addr  out  8  chacha bus address
cc_write_data  out  32  chacha bus write data
cc_read_data  in  32  chacha bus read data; combinational, valid in the same cycle as cc_read
busy  out  1  high from the cycle after start until done or error
done  out  1  one-cycle pulse after the last word is accepted downstream
error  out  1  sticky poll timeout; cleared by the next accepted start
block_count  out  CNT_W  blocks completed in the current message

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0: in_ready, out_valid, out_last, cc_read, cc_write, cc_addr, cc_write_data, busy, done, error, block_count. The internal word index and first-block flag also clear. Reset mid-operation abandons the message and issues no further bus cycles.
- Bus rules: at most one of cc_read and cc_write per cycle. Every bus access takes one cycle. Write addresses: ROUNDS 0x0b; KEY 0x10-0x17; IV 0x20-0x22; DATA_IN 0x40-0x4f; CTRL 0x08 (bit0 init, bit1 next). Read addresses: STATUS 0x09 (bit0 ready, bit1 valid); DATA_OUT 0x80-0x8f.
- IDLE:
  - start is ignored while busy.
  - On start: latch key, iv and rounds; clear block_count and error; set first=1; go to CFG.
- CFG: 12 consecutive write cycles in this order: ROUNDS, KEY0..KEY7, IV0..IV2. Then go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word is written to DATA_IN[idx] in the same cycle, idx increments, and the word is kept in a 16x32 buffer.
  - After word 15, or after in_last, go to PAD with n = words accepted (1..16).
  - in_ready drops combinationally once idx reaches 16 or in_last has been accepted.
- PAD: write 0 to DATA_IN[n..15], one per cycle. Skipped when n=16.
- TRIG: write CTRL = 0x1 if first, else 0x2.
- CLR: the next cycle, write CTRL = 0x0.
- SETTLE: 2 idle bus cycles so a stale ready is not sampled.
- POLL:
  - Read STATUS every cycle.
  - When bits [1:0]==2'b11, go to DRAIN.
  - After TIMEOUT_CYCLES reads without that value, set error, drop busy and return to IDLE.
- DRAIN:
  - For k=0..n-1, read DATA_OUT[k].
  - out_data = cc_read_data XOR buffer[k], presented from the output register on the next cycle.
  - A read is issued only if the output register is empty, or is being emptied this cycle (out_valid && out_ready).
  - out_valid holds with data stable until out_ready.
  - out_last=1 on word n-1 of the final block.
- Block end, once word n-1 has been accepted downstream:
  - block_count increments and first clears.
  - If the block ended on in_last: pulse done, drop busy, go to IDLE.
  - Otherwise go to LOAD.
  - A message that ends exactly on a 16-word boundary requires in_last on word 15.
- Widths and wrap: block_count wraps modulo 2^CNT_W. The chacha counter itself is not managed by this controller.
- Simultaneous events: reset takes priority over start. done and error are never asserted in the same cycle.

Test Plan:
- Reset mid-DRAIN, then release: all outputs 0 and no bus cycles until start.
- Config sequence: start with rounds=20, key=0x00010203..1c1d1e1f, iv=0x000000000000004a00000000 -> bus shows exactly 12 writes in order 0x0b, 0x10-0x17, 0x20-0x22 with matching data, then LOAD.
- Single full block: 16 zero input words with in_last on word 15 -> 16 DATA_IN writes, CTRL 0x1 then 0x0, 16 out words equal to the keystream from a chacha reference model, out_last on word 15, done pulse, block_count=1.
- Partial and multi-block: 37 words -> blocks of 16, 16 and 5; second and third triggers write CTRL=0x2; PAD writes zeros to DATA_IN 5..15; 37 outputs; block_count=3.
- Backpressure: out_ready toggled randomly, including held low 20 cycles -> out_data stable while stalled, no word lost or duplicated, DATA_OUT reads never more than 1 ahead of acceptance.
- Timeout: bus model holds STATUS at 0 with TIMEOUT_CYCLES=8 -> error=1 after 8 polls, busy=0, done stays 0; a new start clears error.

Source files
------------

// File: rtl/chacha_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chacha_stream_ctrl
// Purpose  : Bus master that drives the chacha register block to encrypt or
//            decrypt a message presented as a stream of 32-bit words. Rounds,
//            key and IV are programmed once per message; each 64-byte block is
//            loaded, triggered (init for the first block, next afterwards),
//            polled for completion and drained to the output stream.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            start/key/iv/rounds   - message request and its parameters
//            in_*                  - ready/valid input word stream
//            out_*                 - ready/valid output word stream
//            cc_*                  - chacha register bus (1-cycle accesses)
//            busy/done/error       - message status
//            block_count           - blocks completed in current message
// Revision : 1.0 - initial release
// ============================================================================
module chacha_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [255:0]     key,
  input  logic [95:0]      iv,
  input  logic [4:0]       rounds,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             cc_read,
  output logic             cc_write,
  output logic [7:0]       cc_addr,
  output logic [31:0]      cc_write_data,
  input  logic [31:0]      cc_read_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] block_count
);

  localparam int PW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CFG    = 4'd1;
  localparam logic [3:0] S_LOAD   = 4'd2;
  localparam logic [3:0] S_PAD    = 4'd3;
  localparam logic [3:0] S_TRIG   = 4'd4;
  localparam logic [3:0] S_CLR    = 4'd5;
  localparam logic [3:0] S_SETTLE = 4'd6;
  localparam logic [3:0] S_POLL   = 4'd7;
  localparam logic [3:0] S_DRAIN  = 4'd8;

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_ROUNDS = 8'h0b;
  localparam logic [7:0] A_KEY    = 8'h10;
  localparam logic [7:0] A_IV     = 8'h20;
  localparam logic [7:0] A_DIN    = 8'h40;
  localparam logic [7:0] A_DOUT   = 8'h80;

  logic [3:0]       state_q, state_d;
  logic [255:0]     key_q, key_d;
  logic [95:0]      iv_q, iv_d;
  logic [4:0]       rounds_q, rounds_d;
  logic [4:0]       idx_q, idx_d;        // CFG step, then LOAD/PAD word index
  logic [4:0]       n_q, n_d;            // valid words in the current block
  logic [4:0]       rd_idx_q, rd_idx_d;  // next DATA_OUT word to read
  logic             first_q, first_d;
  logic             last_blk_q, last_blk_d;
  logic             settle_q, settle_d;
  logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_end_q, out_end_d;  // output register holds word n-1
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] block_count_q, block_count_d;

  logic [31:0]      data_buf_q [16];
  logic             buf_we;

  logic             w_accept;
  logic             w_pop;
  logic [2:0]       w_kidx;
  logic [1:0]       w_ividx;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid_q && out_ready;
  assign w_kidx   = 3'(idx_q - 5'd1);
  assign w_ividx  = 2'(idx_q - 5'd9);

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    iv_d          = iv_q;
    rounds_d      = rounds_q;
    idx_d         = idx_q;
    n_d           = n_q;
    rd_idx_d      = rd_idx_q;
    first_d       = first_q;
    last_blk_d    = last_blk_q;
    settle_d      = settle_q;
    poll_cnt_d    = poll_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_end_d     = out_end_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    block_count_d = block_count_q;
    buf_we        = 1'b0;
    in_ready      = 1'b0;
    cc_read       = 1'b0;
    cc_write      = 1'b0;
    cc_addr       = 8'h00;
    cc_write_data = 32'h0;

    // Emptying the output register; a new read below may refill it.
    if (w_pop) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_end_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d         = key;
          iv_d          = iv;
          rounds_d      = rounds;
          block_count_d = '0;
          error_d       = 1'b0;
          first_d       = 1'b1;
          last_blk_d    = 1'b0;
          busy_d        = 1'b1;
          idx_d         = 5'd0;
          state_d       = S_CFG;
        end
      end

      S_CFG: begin
        cc_write = 1'b1;
        if (idx_q == 5'd0) begin
          cc_addr       = A_ROUNDS;
          cc_write_data = {27'd0, rounds_q};
        end else if (idx_q < 5'd9) begin
          cc_addr       = A_KEY | {5'd0, w_kidx};
          cc_write_data = key_q[{3'd7 - w_kidx, 5'd0} +: 32];
        end else begin
          cc_addr       = A_IV | {6'd0, w_ividx};
          cc_write_data = iv_q[{2'd2 - w_ividx, 5'd0} +: 32];
        end
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd11) begin
          idx_d   = 5'd0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Leaving LOAD on word 15 or in_last removes in_ready at once.
        in_ready = !idx_q[4];
        if (w_accept) begin
          cc_write      = 1'b1;
          cc_addr       = A_DIN | {4'd0, idx_q[3:0]};
          cc_write_data = in_data;
          buf_we        = 1'b1;
          idx_d         = idx_q + 5'd1;
          if (in_last || idx_q == 5'd15) begin
            n_d        = idx_q + 5'd1;
            last_blk_d = in_last;
            state_d    = (idx_q == 5'd15) ? S_TRIG : S_PAD;
          end
        end
      end

      S_PAD: begin
        cc_write      = 1'b1;
        cc_addr       = A_DIN | {4'd0, idx_q[3:0]};
        cc_write_data = 32'h0;
        idx_d         = idx_q + 5'd1;
        if (idx_q == 5'd15) state_d = S_TRIG;
      end

      S_TRIG: begin
        cc_write      = 1'b1;
        cc_addr       = A_CTRL;
        cc_write_data = first_q ? 32'h1 : 32'h2;
        state_d       = S_CLR;
      end

      S_CLR: begin
        cc_write      = 1'b1;
        cc_addr       = A_CTRL;
        cc_write_data = 32'h0;
        settle_d      = 1'b0;
        state_d       = S_SETTLE;
      end

      S_SETTLE: begin
        // Two quiet cycles so a ready flag from the previous block is not seen.
        settle_d = 1'b1;
        if (settle_q) begin
          poll_cnt_d = '0;
          state_d    = S_POLL;
        end
      end

      S_POLL: begin
        cc_read = 1'b1;
        cc_addr = A_STATUS;
        if (cc_read_data[1:0] == 2'b11) begin
          rd_idx_d = 5'd0;
          state_d  = S_DRAIN;
        end else if (poll_cnt_q == PW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          poll_cnt_d = poll_cnt_q + PW'(1);
        end
      end

      S_DRAIN: begin
        // Only read when the word can land in the output register now.
        if (rd_idx_q < n_q && (!out_valid_q || out_ready)) begin
          cc_read     = 1'b1;
          cc_addr     = A_DOUT | {4'd0, rd_idx_q[3:0]};
          out_valid_d = 1'b1;
          out_data_d  = cc_read_data ^ data_buf_q[rd_idx_q[3:0]];
          out_end_d   = (rd_idx_q == 5'(n_q - 5'd1));
          out_last_d  = last_blk_q && (rd_idx_q == 5'(n_q - 5'd1));
          rd_idx_d    = rd_idx_q + 5'd1;
        end
        if (w_pop && out_end_q) begin
          block_count_d = block_count_q + CNT_W'(1);
          first_d       = 1'b0;
          idx_d         = 5'd0;
          if (last_blk_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      key_q         <= '0;
      iv_q          <= '0;
      rounds_q      <= '0;
      idx_q         <= '0;
      n_q           <= '0;
      rd_idx_q      <= '0;
      first_q       <= 1'b0;
      last_blk_q    <= 1'b0;
      settle_q      <= 1'b0;
      poll_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_end_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      iv_q          <= iv_d;
      rounds_q      <= rounds_d;
      idx_q         <= idx_d;
      n_q           <= n_d;
      rd_idx_q      <= rd_idx_d;
      first_q       <= first_d;
      last_blk_q    <= last_blk_d;
      settle_q      <= settle_d;
      poll_cnt_q    <= poll_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_end_q     <= out_end_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      block_count_q <= block_count_d;
    end
  end

  // Plaintext/ciphertext copy of the block, XORed back in during DRAIN.
  always_ff @(posedge clk) begin
    if (buf_we) data_buf_q[idx_q[3:0]] <= in_data;
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign block_count = block_count_q;

endmodule
`default_nettype wire

// File: tb/tb_chacha_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha_stream_ctrl
// Purpose  : Self-checking bench for chacha_stream_ctrl with a behavioural
//            chacha register-block model on the bus side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chacha_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last, out_ready;
  logic [255:0] key;
  logic [95:0]  iv;
  logic [4:0]   rounds;
  logic [31:0]  in_data, cc_read_data;
  logic        in_ready, out_valid, out_last, cc_read, cc_write, busy, done, error;
  logic [31:0] out_data, cc_write_data, block_count;
  logic [7:0]  cc_addr;

  always #5 clk = ~clk;

  chacha_stream_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv), .rounds(rounds),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cc_read(cc_read), .cc_write(cc_write), .cc_addr(cc_addr),
    .cc_write_data(cc_write_data), .cc_read_data(cc_read_data),
    .busy(busy), .done(done), .error(error), .block_count(block_count)
  );

  localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  IV_C  = 96'h000000000000004a00000000;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- chacha reference keystream ----------------
  logic [31:0] ks_tab [4][16];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  task automatic gen_block(input int blk);
    logic [31:0] s [16];
    logic [31:0] x [16];
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = KEY_C[255-32*i -: 32];
    s[12] = 32'(blk);
    for (int i = 0; i < 3; i++) s[13+i] = IV_C[95-32*i -: 32];
    x = s;
    for (int r = 0; r < 10; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int j = 0; j < 16; j++) ks_tab[blk][j] = x[j] + s[j];
  endtask

  // ---------------- chacha register-block bus model ----------------
  logic [1:0] st = 2'b00;
  int         st_cnt = 0;
  logic [1:0] model_blk = 2'd0;
  logic       stuck = 1'b0;

  always_comb begin
    cc_read_data = 32'h0;
    if (cc_read) begin
      if (cc_addr == 8'h09) cc_read_data = {30'd0, st};
      else if (cc_addr[7:4] == 4'h8) cc_read_data = ks_tab[model_blk][cc_addr[3:0]];
    end
  end

  always @(posedge clk) begin
    if (cc_write && cc_addr == 8'h08 && cc_write_data[1:0] != 2'b00) begin
      st        <= 2'b00;
      st_cnt    <= 5;
      model_blk <= cc_write_data[0] ? 2'd0 : model_blk + 2'd1;
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1 && !stuck) st <= 2'b11;
    end
  end

  // ---------------- monitor (samples mid-cycle) ----------------
  typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t         wlog [$];
  logic [31:0] cap_data [$];
  logic        cap_last [$];
  int   done_cnt = 0, status_reads = 0, bus_cycles = 0;
  int   both_viol = 0, ahead_viol = 0, stable_viol = 0, de_viol = 0;
  logic stall_pend = 1'b0;
  logic [31:0] stall_data = 32'h0;

  always @(negedge clk) begin
    if (cc_write) wlog.push_back({cc_addr, cc_write_data});
    if (cc_read || cc_write) bus_cycles <= bus_cycles + 1;
    if (cc_read && cc_write) both_viol <= both_viol + 1;
    if (cc_read && cc_addr == 8'h09) status_reads <= status_reads + 1;
    if (cc_read && cc_addr[7] && out_valid && !out_ready) ahead_viol <= ahead_viol + 1;
    if (out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_last.push_back(out_last);
    end
    if (stall_pend && (!out_valid || out_data != stall_data)) stable_viol <= stable_viol + 1;
    stall_pend <= out_valid && !out_ready && !reset;
    stall_data <= out_data;
    if (done) done_cnt <= done_cnt + 1;
    if (done && error) de_viol <= de_viol + 1;
  end

  // ---------------- output sink ----------------
  int sink_mode = 0;  // 0 always ready, 1 random, 2 hold low 20 cycles then random, 3 never
  int hold_cnt  = 0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (hold_cnt < 20) begin
            out_ready = 1'b0;
            if (out_valid) hold_cnt++;
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] msg [64];

  task automatic make_msg(input int n, input int seed);
    for (int i = 0; i < n; i++)
      msg[i] = (seed == 0) ? 32'h0 : ((32'(seed) * 32'h1000_0001) ^ (32'(i) * 32'h9E37_79B9));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = msg[i]; in_last = (i == n - 1);
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 600) begin @(negedge clk); g++; end
      if (!in_ready) begin
        check("feed_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  typedef struct {
    int n; int seed; int mode; int blocks; int dw; int cw;
  } vec_t;

  task automatic run_and_check(input vec_t v);
    int w0, c0, d0, g, nd, nc, bad_d, bad_c, bad_o, bad_cfg;
    logic [39:0] exp_w;
    logic [31:0] exp_d;
    make_msg(v.n, v.seed);
    sink_mode = v.mode; hold_cnt = 0;
    w0 = wlog.size(); c0 = cap_data.size(); d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    check($sformatf("busy_after_start_n%0d", v.n), 128'(busy), 128'(1));
    check($sformatf("error_clear_n%0d", v.n), 128'(error), 128'(0));
    fork
      feed(v.n);
      begin
        g = 0;
        while (done_cnt == d0 && g < 4000) begin @(negedge clk); g++; end
      end
    join
    @(negedge clk);
    check($sformatf("done_pulses_n%0d", v.n), 128'(done_cnt - d0), 128'(1));
    check($sformatf("busy_end_n%0d", v.n), 128'(busy), 128'(0));
    check($sformatf("block_count_n%0d", v.n), 128'(block_count), 128'(v.blocks));
    check($sformatf("out_count_n%0d", v.n), 128'(cap_data.size() - c0), 128'(v.n));
    for (int i = 0; i < v.n && c0 + i < cap_data.size(); i++)
      check($sformatf("out_word_n%0d_%0d", v.n, i), 128'({cap_last[c0+i], cap_data[c0+i]}),
            128'({(i == v.n - 1), msg[i] ^ ks_tab[i/16][i%16]}));
    bad_cfg = 0;
    for (int j = 0; j < 12; j++) begin
      if (j == 0)      exp_w = {8'h0b, 32'd20};
      else if (j < 9)  exp_w = {8'(8'h10 + j - 1), KEY_C[255-32*(j-1) -: 32]};
      else             exp_w = {8'(8'h20 + j - 9), IV_C[95-32*(j-9) -: 32]};
      if (w0 + j >= wlog.size() || wlog[w0+j] != exp_w) bad_cfg++;
    end
    check($sformatf("cfg_writes_bad_n%0d", v.n), 128'(bad_cfg), 128'(0));
    nd = 0; nc = 0; bad_d = 0; bad_c = 0; bad_o = 0;
    for (int k = w0 + 12; k < wlog.size(); k++) begin
      if (wlog[k].a[7:4] == 4'h4) begin
        exp_d = (nd < v.n) ? msg[nd] : 32'h0;
        if (wlog[k].a[3:0] != 4'(nd) || wlog[k].d != exp_d) bad_d++;
        nd++;
      end else if (wlog[k].a == 8'h08) begin
        exp_d = (nc % 2 == 1) ? 32'h0 : ((nc == 0) ? 32'h1 : 32'h2);
        if (wlog[k].d != exp_d) bad_c++;
        nc++;
      end else begin
        bad_o++;
      end
    end
    check($sformatf("datain_writes_n%0d", v.n), 128'(nd), 128'(v.dw));
    check($sformatf("datain_content_bad_n%0d", v.n), 128'(bad_d), 128'(0));
    check($sformatf("ctrl_writes_n%0d", v.n), 128'(nc), 128'(v.cw));
    check($sformatf("ctrl_content_bad_n%0d", v.n), 128'(bad_c), 128'(0));
    check($sformatf("stray_writes_n%0d", v.n), 128'(bad_o), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs [5];

  initial begin
    int g, s0, d0, b0;
    vecs[0] = '{n:16, seed:0, mode:0, blocks:1, dw:16, cw:2};
    vecs[1] = '{n:37, seed:1, mode:0, blocks:3, dw:48, cw:6};
    vecs[2] = '{n:37, seed:2, mode:1, blocks:3, dw:48, cw:6};
    vecs[3] = '{n:20, seed:3, mode:2, blocks:2, dw:32, cw:4};
    vecs[4] = '{n:1,  seed:4, mode:1, blocks:1, dw:16, cw:2};

    for (int b = 0; b < 4; b++) gen_block(b);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
    key = KEY_C; iv = IV_C; rounds = 5'd20;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", 128'({in_ready, out_valid, out_last, cc_read, cc_write, cc_addr,
          cc_write_data, busy, done, error, block_count}), 128'(0));

    for (int i = 0; i < 5; i++) run_and_check(vecs[i]);

    // Poll timeout: STATUS never reports ready.
    stuck = 1'b1; sink_mode = 0;
    make_msg(3, 7);
    s0 = status_reads; d0 = done_cnt;
    pulse_start();
    fork
      feed(3);
      begin
        g = 0;
        while (!error && g < 2000) begin @(negedge clk); g++; end
      end
    join
    @(negedge clk);
    check("timeout_error", 128'(error), 128'(1));
    check("timeout_busy", 128'(busy), 128'(0));
    check("timeout_polls", 128'(status_reads - s0), 128'(8));
    check("timeout_no_done", 128'(done_cnt - d0), 128'(0));
    check("timeout_block_count", 128'(block_count), 128'(0));
    repeat (5) @(negedge clk);
    check("error_sticky", 128'(error), 128'(1));
    stuck = 1'b0;
    run_and_check('{n:5, seed:5, mode:0, blocks:1, dw:16, cw:2});

    // Reset while DRAIN is stalled on a full output register.
    sink_mode = 3;
    make_msg(16, 6);
    pulse_start();
    fork
      feed(16);
      begin
        g = 0;
        while (!out_valid && g < 2000) begin @(negedge clk); g++; end
      end
    join
    check("drain_reached", 128'(out_valid), 128'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    b0 = bus_cycles;
    @(negedge clk);
    check("midreset_outputs", 128'({in_ready, out_valid, out_last, cc_read, cc_write, cc_addr,
          cc_write_data, busy, done, error, block_count}), 128'(0));
    repeat (10) @(negedge clk);
    check("midreset_no_bus", 128'(bus_cycles - b0), 128'(0));
    check("midreset_busy", 128'(busy), 128'(0));
    run_and_check('{n:16, seed:6, mode:0, blocks:1, dw:16, cw:2});

    check("rd_wr_same_cycle", 128'(both_viol), 128'(0));
    check("read_ahead", 128'(ahead_viol), 128'(0));
    check("stall_stability", 128'(stable_viol), 128'(0));
    check("done_with_error", 128'(de_viol), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
